// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter
// Merges icache and dcache read bursts onto a single AXI3-style AR/R channel.
// Each cache may have at most one burst outstanding; both may be in flight
// at once. R beats are steered back to their owner by RID.
//
// Handshake semantics: a transfer on AR happens on a rising clk edge where
// ar_valid and ar_ready are both 1. ar_valid is driven from a register and,
// once raised, stays high with ar_addr/ar_len/ar_id frozen until that edge.
// The R channel never back-pressures: r_ready is 1 whenever any burst is
// outstanding, and the owning cache must take each beat in the cycle it is
// presented.
//
// Optional feature: define MEM_RD_ARB_RR_EN for round-robin tie breaking.
// Without it, dcache always wins a tie and no rr_last register exists.
//
// dbg_state_o exposes the AR FSM state (0 = IDLE, 1 = ISSUE).

module mem_rd_arbiter #(
    parameter logic [3:0] IC_ID = 4'd0,
    parameter logic [3:0] DC_ID = 4'd1,
    parameter int         LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,

    // icache side
    input  logic             ic_req,
    input  logic [31:0]      ic_addr,
    input  logic [LEN_W-1:0] ic_len,
    output logic             ic_gnt,
    output logic             ic_rvalid,

    // dcache side
    input  logic             dc_req,
    input  logic [31:0]      dc_addr,
    input  logic [LEN_W-1:0] dc_len,
    output logic             dc_gnt,
    output logic             dc_rvalid,

    // shared return data
    output logic [31:0]      rd_data,
    output logic             rd_last,

    // AXI AR channel
    output logic             ar_valid,
    input  logic             ar_ready,
    output logic [31:0]      ar_addr,
    output logic [LEN_W-1:0] ar_len,
    output logic [3:0]       ar_id,

    // AXI R channel
    input  logic             r_valid,
    output logic             r_ready,
    input  logic [31:0]      r_data,
    input  logic             r_last,
    input  logic [3:0]       r_id,

    // FSM observation
    output logic             dbg_state_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    typedef enum logic {
        M_IC = 1'b0,
        M_DC = 1'b1
    } master_e;

    state_e           state_q, state_d;
    master_e          win_q, win_d;

    logic             ar_valid_q, ar_valid_d;
    logic [31:0]      ar_addr_q, ar_addr_d;
    logic [LEN_W-1:0] ar_len_q, ar_len_d;
    logic [3:0]       ar_id_q, ar_id_d;

    logic             ic_gnt_q, ic_gnt_d;
    logic             dc_gnt_q, dc_gnt_d;
    logic             ic_out_q, ic_out_d;
    logic             dc_out_q, dc_out_d;

`ifdef MEM_RD_ARB_RR_EN
    master_e          rr_last_q, rr_last_d;
`endif

    logic             ic_elig;
    logic             dc_elig;
    logic             pick_dc;
    logic             ar_hs;
    logic             ic_beat;
    logic             dc_beat;

    // A cache may only compete when it has no burst outstanding.
    assign ic_elig = ic_req & ~ic_out_q;
    assign dc_elig = dc_req & ~dc_out_q;
    assign ar_hs   = ar_valid_q & ar_ready;

    // R path: beats are accepted only for an ID that owns an outstanding burst.
    assign ic_beat = r_valid & (r_id == IC_ID) & ic_out_q;
    assign dc_beat = r_valid & (r_id == DC_ID) & dc_out_q;

    // Winner selection among eligible requesters; only consumed in IDLE.
    always_comb begin
        pick_dc = 1'b0;
        if (ic_elig && dc_elig) begin
`ifdef MEM_RD_ARB_RR_EN
            // The master not granted last time takes the tie.
            pick_dc = (rr_last_q == M_IC);
`else
            // Fixed priority: dcache misses stall loads, so they go first.
            pick_dc = 1'b1;
`endif
        end else begin
            pick_dc = dc_elig;
        end
    end

    // AR FSM next-state and registered-output next values.
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        ar_valid_d = ar_valid_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_id_d    = ar_id_q;
        ic_gnt_d   = 1'b0;
        dc_gnt_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ic_elig || dc_elig) begin
                    state_d    = ST_ISSUE;
                    ar_valid_d = 1'b1;
                    win_d      = pick_dc ? M_DC : M_IC;
                    ar_addr_d  = pick_dc ? dc_addr : ic_addr;
                    ar_len_d   = pick_dc ? dc_len : ic_len;
                    ar_id_d    = pick_dc ? DC_ID : IC_ID;
                end
            end
            ST_ISSUE: begin
                // No re-arbitration here: the registered request is held
                // until the bridge takes it.
                if (ar_hs) begin
                    state_d    = ST_IDLE;
                    ar_valid_d = 1'b0;
                    if (win_q == M_DC) begin
                        dc_gnt_d = 1'b1;
                    end else begin
                        ic_gnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                ar_valid_d = 1'b0;
            end
        endcase
    end

    // Outstanding flags: set on the AR handshake, cleared by the owner's last beat.
    // Set and clear of the same ID cannot coincide because out=1 blocks a new grant.
    always_comb begin
        ic_out_d = ic_out_q;
        dc_out_d = dc_out_q;
        if (ic_gnt_d) begin
            ic_out_d = 1'b1;
        end else if (ic_beat && r_last) begin
            ic_out_d = 1'b0;
        end
        if (dc_gnt_d) begin
            dc_out_d = 1'b1;
        end else if (dc_beat && r_last) begin
            dc_out_d = 1'b0;
        end
    end

`ifdef MEM_RD_ARB_RR_EN
    // Round-robin history follows the master granted at each AR handshake.
    always_comb begin
        rr_last_d = rr_last_q;
        if (ar_hs) begin
            rr_last_d = win_q;
        end
    end

    // Round-robin history register; reset so icache wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q <= M_DC;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

    // State, AR registers, grant pulses and outstanding flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            win_q      <= M_IC;
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_id_q    <= '0;
            ic_gnt_q   <= 1'b0;
            dc_gnt_q   <= 1'b0;
            ic_out_q   <= 1'b0;
            dc_out_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            ar_valid_q <= ar_valid_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_id_q    <= ar_id_d;
            ic_gnt_q   <= ic_gnt_d;
            dc_gnt_q   <= dc_gnt_d;
            ic_out_q   <= ic_out_d;
            dc_out_q   <= dc_out_d;
        end
    end

    assign ar_valid    = ar_valid_q;
    assign ar_addr     = ar_addr_q;
    assign ar_len      = ar_len_q;
    assign ar_id       = ar_id_q;
    assign ic_gnt      = ic_gnt_q;
    assign dc_gnt      = dc_gnt_q;

    assign r_ready     = ic_out_q | dc_out_q;
    assign ic_rvalid   = ic_beat;
    assign dc_rvalid   = dc_beat;
    assign rd_data     = r_data;
    assign rd_last     = r_last;

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Bench for mem_rd_arbiter. Expected AR requests and R routing results are
// pushed to queues when stimulus is driven and popped when the DUT responds.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// then or 1 more unit later, never on the edge.

module tb_mem_rd_arbiter;

    localparam logic [3:0] IC = 4'd0;
    localparam logic [3:0] DC = 4'd1;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_req, dc_req;
    logic [31:0] ic_addr, dc_addr;
    logic [7:0]  ic_len, dc_len;
    logic        ic_gnt, dc_gnt, ic_rvalid, dc_rvalid;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        ar_valid, ar_ready;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [3:0]  ar_id;
    logic        r_valid, r_ready, r_last;
    logic [31:0] r_data;
    logic [3:0]  r_id;
    logic        dbg_state;

    int checks = 0;
    int errors = 0;

    logic [43:0] exp_ar_q[$];
    logic [34:0] exp_r_q[$];

    mem_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_len(ic_len),
        .ic_gnt(ic_gnt), .ic_rvalid(ic_rvalid),
        .dc_req(dc_req), .dc_addr(dc_addr), .dc_len(dc_len),
        .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid),
        .rd_data(rd_data), .rd_last(rd_last),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
        .ar_len(ar_len), .ar_id(ar_id),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
        .r_last(r_last), .r_id(r_id),
        .dbg_state_o(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ic_req = 0; ic_addr = '0; ic_len = '0;
        dc_req = 0; dc_addr = '0; dc_len = '0;
        ar_ready = 1; r_valid = 0; r_data = '0; r_last = 0; r_id = '0;
    endtask

    task automatic drive_beat(input logic [3:0] id, input logic [31:0] d, input logic last);
        r_valid = 1; r_id = id; r_data = d; r_last = last;
    endtask

    // Waits (bounded) for a grant pulse; n = cycles taken or -1 on timeout.
    task automatic wait_gnt(input int max_cyc, output int n,
                            output logic [43:0] ar_seen, output logic [1:0] g);
        n = -1; ar_seen = '0; g = 2'b00;
        for (int i = 1; i <= max_cyc; i++) begin
            if (ar_valid && ar_ready) ar_seen = {ar_id, ar_len, ar_addr};
            cyc();
            if (ic_gnt || dc_gnt) begin
                n = i;
                g = {dc_gnt, ic_gnt};
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [52:0] got;
        idle_inputs();
        rst = 1;
        repeat (3) cyc();
        r_valid = 1; r_id = IC; r_last = 1; r_data = 32'hdead_beef;
        #1;
        got = {ar_valid, ar_addr, ar_len, ar_id, ic_gnt, dc_gnt, r_ready,
               ic_rvalid, dc_rvalid, dbg_state};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", got);
        end
        r_valid = 0; r_last = 0;
        rst = 0;
        cyc();
    endtask

    task automatic test_single();
        logic [43:0] e;
        logic [34:0] er;
        logic [31:0] d;
        ic_req = 1; ic_addr = 32'h1c00_0000; ic_len = 8'd3; ar_ready = 1;
        exp_ar_q.push_back({IC, 8'd3, 32'h1c00_0000});
        cyc();
        checks++;
        if ({ar_valid, ic_gnt, dc_gnt} !== 3'b100) begin
            errors++;
            $display("FAIL single_arvalid got v%b ig%b dg%b exp v1 ig0 dg0", ar_valid, ic_gnt, dc_gnt);
        end
        e = exp_ar_q.pop_front();
        checks++;
        if ({ar_id, ar_len, ar_addr} !== e) begin
            errors++;
            $display("FAIL single_ar_fields got %h exp %h", {ar_id, ar_len, ar_addr}, e);
        end
        cyc();
        checks++;
        if ({ar_valid, ic_gnt, dc_gnt} !== 3'b010) begin
            errors++;
            $display("FAIL single_gnt got v%b ig%b dg%b exp v0 ig1 dg0", ar_valid, ic_gnt, dc_gnt);
        end
        ic_req = 0;
        cyc();
        checks++;
        if ({ic_gnt, r_ready} !== 2'b01) begin
            errors++;
            $display("FAIL single_pulse got ig%b rr%b exp ig0 rr1", ic_gnt, r_ready);
        end
        for (int b = 0; b < 4; b++) begin
            d = $urandom;
            drive_beat(IC, d, b == 3);
            exp_r_q.push_back({1'b1, 1'b0, (b == 3), d});
            #1;
            er = exp_r_q.pop_front();
            checks++;
            if ({ic_rvalid, dc_rvalid, rd_last, rd_data} !== er) begin
                errors++;
                $display("FAIL single_beat%0d got %h exp %h", b,
                         {ic_rvalid, dc_rvalid, rd_last, rd_data}, er);
            end
            cyc();
        end
        r_valid = 0; r_last = 0;
        #1;
        checks++;
        if (r_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_flag_clear got r_ready %b exp 0", r_ready);
        end
    endtask

    task automatic test_tie();
        int n;
        logic [43:0] ar, e;
        logic [1:0] g;
        logic ic_first;
`ifdef MEM_RD_ARB_RR_EN
        ic_first = 1;
`else
        ic_first = 0;
`endif
        ic_req = 1; ic_addr = 32'h1000_0040; ic_len = 8'd7;
        dc_req = 1; dc_addr = 32'h2000_0080; dc_len = 8'd1;
        if (ic_first) begin
            exp_ar_q.push_back({IC, 8'd7, 32'h1000_0040});
            exp_ar_q.push_back({DC, 8'd1, 32'h2000_0080});
        end else begin
            exp_ar_q.push_back({DC, 8'd1, 32'h2000_0080});
            exp_ar_q.push_back({IC, 8'd7, 32'h1000_0040});
        end
        for (int k = 0; k < 2; k++) begin
            wait_gnt(20, n, ar, g);
            e = exp_ar_q.pop_front();
            checks++;
            if (n !== 2 || ar !== e || g !== ((e[43:40] == IC) ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL tie_grant%0d got n=%0d ar=%h g=%b exp n=2 ar=%h", k, n, ar, g, e);
            end
            if (e[43:40] == IC) ic_req = 0; else dc_req = 0;
        end
        checks++;
        if (r_ready !== 1'b1) begin
            errors++;
            $display("FAIL tie_both_out got r_ready %b exp 1", r_ready);
        end
    endtask

    task automatic test_interleave();
        logic [3:0] ids[6];
        bit lasts[6];
        bit eic[6];
        bit edc[6];
        logic [34:0] er;
        logic [31:0] d;
        ids   = '{DC, IC, DC, DC, 4'd5, IC};
        lasts = '{0, 0, 1, 1, 0, 1};
        eic   = '{0, 1, 0, 0, 0, 1};
        edc   = '{1, 0, 1, 0, 0, 0};
        for (int b = 0; b < 6; b++) begin
            d = $urandom;
            drive_beat(ids[b], d, lasts[b]);
            exp_r_q.push_back({eic[b], edc[b], lasts[b], d});
            #1;
            er = exp_r_q.pop_front();
            checks++;
            if ({ic_rvalid, dc_rvalid, rd_last, rd_data} !== er || r_ready !== 1'b1) begin
                errors++;
                $display("FAIL interleave_beat%0d got %h rr%b exp %h rr1", b,
                         {ic_rvalid, dc_rvalid, rd_last, rd_data}, r_ready, er);
            end
            cyc();
        end
        r_valid = 0; r_last = 0;
        #1;
        checks++;
        if (r_ready !== 1'b0) begin
            errors++;
            $display("FAIL interleave_flags_clear got r_ready %b exp 0", r_ready);
        end
    endtask

    task automatic test_stall();
        int n;
        logic [43:0] ar, e;
        logic [1:0] g;
        logic [34:0] er;
        logic [31:0] d;
        ar_ready = 0;
        dc_req = 1; dc_addr = 32'h3000_0100; dc_len = 8'd15;
        exp_ar_q.push_back({DC, 8'd15, 32'h3000_0100});
        cyc();
        checks++;
        if ({ar_valid, dbg_state, ar_id, ar_len, ar_addr} !== {2'b11, exp_ar_q[0]}) begin
            errors++;
            $display("FAIL stall_first got v%b st%b %h exp v1 st1 %h", ar_valid, dbg_state,
                     {ar_id, ar_len, ar_addr}, exp_ar_q[0]);
        end
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                ic_req = 1; ic_addr = 32'h1c00_0200; ic_len = 8'd3;
            end
            cyc();
            checks++;
            if ({ar_valid, ic_gnt, dc_gnt, ar_id, ar_len, ar_addr} !== {3'b100, exp_ar_q[0]}) begin
                errors++;
                $display("FAIL stall_hold%0d got v%b ig%b dg%b %h exp v1 ig0 dg0 %h", k,
                         ar_valid, ic_gnt, dc_gnt, {ar_id, ar_len, ar_addr}, exp_ar_q[0]);
            end
        end
        ar_ready = 1;
        wait_gnt(20, n, ar, g);
        e = exp_ar_q.pop_front();
        checks++;
        if (n !== 1 || ar !== e || g !== 2'b10) begin
            errors++;
            $display("FAIL stall_dc_gnt got n=%0d ar=%h g=%b exp n=1 ar=%h g=10", n, ar, g, e);
        end
        dc_req = 0;
        exp_ar_q.push_back({IC, 8'd3, 32'h1c00_0200});
        wait_gnt(20, n, ar, g);
        e = exp_ar_q.pop_front();
        checks++;
        if (n !== 2 || ar !== e || g !== 2'b01) begin
            errors++;
            $display("FAIL stall_ic_after got n=%0d ar=%h g=%b exp n=2 ar=%h g=01", n, ar, g, e);
        end
        ic_req = 0;
        // retire both bursts with their last beats
        for (int b = 0; b < 2; b++) begin
            d = $urandom;
            drive_beat((b == 0) ? IC : DC, d, 1'b1);
            exp_r_q.push_back({(b == 0), (b == 1), 1'b1, d});
            #1;
            er = exp_r_q.pop_front();
            checks++;
            if ({ic_rvalid, dc_rvalid, rd_last, rd_data} !== er) begin
                errors++;
                $display("FAIL stall_retire%0d got %h exp %h", b,
                         {ic_rvalid, dc_rvalid, rd_last, rd_data}, er);
            end
            cyc();
        end
        r_valid = 0; r_last = 0;
    endtask

    task automatic test_back_to_back();
        int n;
        logic [43:0] ar, e;
        logic [1:0] g;
        logic [31:0] d;
        dc_req = 1; dc_addr = 32'h3000_0400; dc_len = 8'd0;
        exp_ar_q.push_back({DC, 8'd0, 32'h3000_0400});
        wait_gnt(20, n, ar, g);
        e = exp_ar_q.pop_front();
        checks++;
        if (n !== 2 || ar !== e || g !== 2'b10) begin
            errors++;
            $display("FAIL b2b_first got n=%0d ar=%h g=%b exp n=2 ar=%h g=10", n, ar, g, e);
        end
        dc_addr = 32'h3000_0500; dc_len = 8'd2;
        exp_ar_q.push_back({DC, 8'd2, 32'h3000_0500});
        for (int k = 0; k < 4; k++) begin
            cyc();
            checks++;
            if ({ar_valid, dc_gnt} !== 2'b00) begin
                errors++;
                $display("FAIL b2b_blocked%0d got v%b dg%b exp v0 dg0", k, ar_valid, dc_gnt);
            end
        end
        d = $urandom;
        drive_beat(DC, d, 1'b1);
        #1;
        checks++;
        if ({ic_rvalid, dc_rvalid, rd_last, rd_data} !== {3'b011, d}) begin
            errors++;
            $display("FAIL b2b_single_beat got %h exp %h", {ic_rvalid, dc_rvalid, rd_last, rd_data},
                     {3'b011, d});
        end
        cyc();
        r_valid = 0; r_last = 0;
        wait_gnt(20, n, ar, g);
        e = exp_ar_q.pop_front();
        checks++;
        if (n !== 2 || ar !== e || g !== 2'b10) begin
            errors++;
            $display("FAIL b2b_regrant got n=%0d ar=%h g=%b exp n=2 ar=%h g=10", n, ar, g, e);
        end
        dc_req = 0;
    endtask

    task automatic test_reset_mid();
        int n;
        logic [43:0] ar, e;
        logic [1:0] g;
        logic [31:0] d;
        logic [52:0] got;
        logic ic_first;
`ifdef MEM_RD_ARB_RR_EN
        ic_first = 1;
`else
        ic_first = 0;
`endif
        ic_req = 1; ic_addr = 32'h1c00_0300; ic_len = 8'd7;
        exp_ar_q.push_back({IC, 8'd7, 32'h1c00_0300});
        wait_gnt(20, n, ar, g);
        e = exp_ar_q.pop_front();
        checks++;
        if (n !== 2 || ar !== e || g !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_grant got n=%0d ar=%h g=%b exp n=2 ar=%h g=01", n, ar, g, e);
        end
        ic_req = 0;
        for (int b = 0; b < 2; b++) begin
            d = $urandom;
            drive_beat(IC, d, 1'b0);
            #1;
            checks++;
            if ({ic_rvalid, rd_data} !== {1'b1, d}) begin
                errors++;
                $display("FAIL rstmid_beat%0d got %h exp %h", b, {ic_rvalid, rd_data}, {1'b1, d});
            end
            if (b == 1) rst = 1;
            cyc();
        end
        #1;
        got = {ar_valid, ar_addr, ar_len, ar_id, ic_gnt, dc_gnt, r_ready,
               ic_rvalid, dc_rvalid, dbg_state};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got %h exp 0", got);
        end
        rst = 0;
        cyc();
        for (int b = 0; b < 3; b++) begin
            drive_beat(IC, $urandom, b == 2);
            #1;
            checks++;
            if ({ic_rvalid, dc_rvalid, r_ready} !== 3'b000) begin
                errors++;
                $display("FAIL rstmid_stray%0d got ir%b dr%b rr%b exp 000", b, ic_rvalid, dc_rvalid, r_ready);
            end
            cyc();
        end
        r_valid = 0; r_last = 0;
        // post-reset tie: priority state is back at its reset value
        ic_req = 1; ic_addr = 32'h1c00_0400; ic_len = 8'd1;
        dc_req = 1; dc_addr = 32'h2000_0400; dc_len = 8'd1;
        wait_gnt(20, n, ar, g);
        checks++;
        if (n !== 2 || g !== (ic_first ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL rstmid_tie got n=%0d g=%b exp n=2 g=%b", n, g, ic_first ? 2'b01 : 2'b10);
        end
        if (ic_first) ic_req = 0; else dc_req = 0;
        wait_gnt(20, n, ar, g);
        checks++;
        if (n !== 2 || g !== (ic_first ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL rstmid_tie2 got n=%0d g=%b exp n=2 g=%b", n, g, ic_first ? 2'b10 : 2'b01);
        end
        ic_req = 0; dc_req = 0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_tie();
        test_interleave();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_ar_q.size() != 0 || exp_r_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got ar=%0d r=%0d exp 0 0", exp_ar_q.size(), exp_r_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
